// File: rtl/nn_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_io_pkg
// Brief    : Shared types and helpers for the network input loader.
// Revision : 1.0 - initial release
// ============================================================================
package nn_io_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        PEND     = 2'd2,
        WAIT_END = 2'd3
    } loader_state_t;

    // Width of one complete frame in bits
    function automatic int total_bits(input int numInputs, input int dataWidth);
        return numInputs * dataWidth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : serial_sync_edge
// Brief    : Synchronises one asynchronous serial line into the system clock
//            domain and produces a registered level with aligned rise/fall
//            pulses. Level and pulses come out of the same register stage so
//            a data line sampled on a clock-line rise stays consistent.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    // Metastability chain for the asynchronous input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    // Registered level and edge pulses, all aligned to the same cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_level <= r_sync[SYNC_STAGES-1];
            r_rise  <= r_sync[SYNC_STAGES-1] & ~r_level;
            r_fall  <= ~r_sync[SYNC_STAGES-1] & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/serial_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_loader
// Brief    : Loads one frame of numInputs x dataWidth bits from a framed,
//            oversampled serial link (MSB first) and hands it to the network
//            input layer over valid/ready with a one-frame holding buffer.
//            Aborted, overrun and stalled frames pulse frameError.
// Config   : define INPUT_LOADER_TIMEOUT_EN to abort frames that stall in
//            SHIFT for TIMEOUT_CYCLES cycles; otherwise SHIFT waits forever.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_loader
    import nn_io_pkg::*;
#(
    parameter int numInputs      = 784,
    parameter int dataWidth      = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                                       CLOCK_50,
    input  logic                                       reset_n,
    input  logic                                       serialClock,
    input  logic                                       serialData,
    input  logic                                       serialFrame,
    input  logic                                       outReady,
    output logic [total_bits(numInputs, dataWidth)-1:0] dataOut,
    output logic                                       outValid,
    output logic                                       busy,
    output logic                                       frameError
);

    localparam int                c_total   = total_bits(numInputs, dataWidth);
    localparam int                c_cntW    = $clog2(c_total + 1);
    localparam logic [c_cntW-1:0] c_lastIdx = c_cntW'(c_total - 1);
    localparam int                c_clkIdx  = 0;
    localparam int                c_datIdx  = 1;
    localparam int                c_frmIdx  = 2;

    logic [2:0]         w_async;
    logic [2:0]         w_level;
    logic [2:0]         w_rise;
    logic [2:0]         w_fall;
    logic               w_bitEvent;
    logic               w_bitData;
    logic               w_frameLevel;
    logic               w_frameRise;
    logic               w_timeout;
    logic               w_unusedSync;

    loader_state_t      r_state;
    logic [c_total-1:0] r_sreg;
    logic [c_cntW-1:0]  r_cnt;
    logic [c_total-1:0] r_dataOut;
    logic               r_outValid;
    logic               r_frameError;

    assign w_async = {serialFrame, serialData, serialClock};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        serial_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .i_clk  (CLOCK_50),
            .i_rst_n(reset_n),
            .i_async(w_async[gi]),
            .o_level(w_level[gi]),
            .o_rise (w_rise[gi]),
            .o_fall (w_fall[gi])
        );
    end

    // Bit events come from the clock line; data is taken from the same stage
    assign w_bitEvent   = w_rise[c_clkIdx];
    assign w_bitData    = w_level[c_datIdx];
    assign w_frameLevel = w_level[c_frmIdx];
    assign w_frameRise  = w_rise[c_frmIdx];
    assign w_unusedSync = ^{w_level[c_clkIdx], w_rise[c_datIdx], w_fall};

`ifdef INPUT_LOADER_TIMEOUT_EN
    localparam int                  c_timerW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_timerW-1:0] c_timerLast = c_timerW'(TIMEOUT_CYCLES - 1);

    logic [c_timerW-1:0] r_timer;

    // Counts consecutive SHIFT cycles without a bit event
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (r_state == SHIFT && !w_bitEvent) begin
            r_timer <= r_timer + 1'b1;
        end else begin
            r_timer <= '0;
        end
    end

    assign w_timeout = (r_state == SHIFT) && !w_bitEvent && (r_timer == c_timerLast);
`else
    localparam int c_unusedTimeout = TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
`endif

    // Frame assembly, holding buffer and error reporting
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_sreg       <= '0;
            r_cnt        <= '0;
            r_dataOut    <= '0;
            r_outValid   <= 1'b0;
            r_frameError <= 1'b0;
        end else begin
            r_frameError <= 1'b0;
            // A consumed frame frees the slot; a PEND load below overrides this
            if (r_outValid && outReady) begin
                r_outValid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_frameRise) begin
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The final bit wins over a coincident frame fall
                    if (w_bitEvent && r_cnt == c_lastIdx) begin
                        r_sreg  <= {r_sreg[c_total-2:0], w_bitData};
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= PEND;
                    end else if (!w_frameLevel) begin
                        r_frameError <= 1'b1;
                        r_sreg       <= '0;
                        r_cnt        <= '0;
                        r_state      <= IDLE;
                    end else if (w_timeout) begin
                        r_frameError <= 1'b1;
                        r_sreg       <= '0;
                        r_cnt        <= '0;
                        r_state      <= WAIT_END;
                    end else if (w_bitEvent) begin
                        r_sreg <= {r_sreg[c_total-2:0], w_bitData};
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                PEND: begin
                    if (w_bitEvent) begin
                        r_frameError <= 1'b1;
                    end
                    if (!r_outValid || outReady) begin
                        r_dataOut  <= r_sreg;
                        r_outValid <= 1'b1;
                        r_state    <= w_frameLevel ? WAIT_END : IDLE;
                    end
                end
                WAIT_END: begin
                    if (w_bitEvent) begin
                        r_frameError <= 1'b1;
                    end
                    if (!w_frameLevel) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dataOut    = r_dataOut;
    assign outValid   = r_outValid;
    assign frameError = r_frameError;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire
